// File: rtl/sext_pipe.sv
// sext_pipe: registered immediate extender with a 2-entry skid buffer.
// The immediate is extended as the instruction arrives, and the result is stored
// in the buffer together with its tag and an illegal-opcode flag. The result
// leaves one cycle later through a valid/ready handshake.
// The optional macro SEXT_PIPE_TGT_EN adds a registered `tgt` output, equal to out_tag + ext.
// XLEN must be 32 or 64.
module sext_pipe #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      inst,
   input  logic [2:0]       ext_op,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  ext,
   output logic [TAG_W-1:0] out_tag,
   output logic             op_err
`ifdef SEXT_PIPE_TGT_EN
   ,output logic [XLEN-1:0] tgt
`endif
);

   localparam logic [2:0] EXT_I  = 3'd0;
   localparam logic [2:0] EXT_S  = 3'd1;
   localparam logic [2:0] EXT_B  = 3'd2;
   localparam logic [2:0] EXT_J  = 3'd3;
   localparam logic [2:0] EXT_U  = 3'd4;
   localparam logic [2:0] EXT_Z  = 3'd5;
   localparam logic [2:0] EXT_SH = 3'd6;

   typedef struct packed {
      logic [XLEN-1:0]  ext;
      logic [TAG_W-1:0] tag;
      logic             err;
`ifdef SEXT_PIPE_TGT_EN
      logic [XLEN-1:0]  tgt;
`endif
   } entry_t;

   logic [63:0] ext_wide;
   logic        err_in;
   entry_t      in_e;
   entry_t      m_q;
   entry_t      s_q;
   logic        m_valid;
   logic        s_valid;
   logic        in_xfer;
   logic        out_xfer;
   logic        advance;
   logic        m_load_s;
   logic        m_load_in;
   logic        s_load_in;
   logic        unused_bits;

   // Every format is built at 64 bits and then cut down to XLEN, so the same
   // sign-extension expressions serve both widths.
   always_comb begin
      ext_wide = '0;
      err_in   = 1'b0;
      case (ext_op)
         EXT_I:  ext_wide = {{52{inst[31]}}, inst[31:20]};
         EXT_S:  ext_wide = {{52{inst[31]}}, inst[31:25], inst[11:7]};
         EXT_B:  ext_wide = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         EXT_J:  ext_wide = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         EXT_U:  ext_wide = {{32{inst[31]}}, inst[31:12], 12'b0};
         EXT_Z:  ext_wide = {59'b0, inst[19:15]};
         EXT_SH: ext_wide = (XLEN == 64) ? {58'b0, inst[25:20]} : {59'b0, inst[24:20]};
         default: err_in = 1'b1;
      endcase
   end

   assign unused_bits = ^{inst[6:0], ext_wide};

   assign in_e.ext = ext_wide[XLEN-1:0];
   assign in_e.tag = in_tag;
   assign in_e.err = err_in;

`ifdef SEXT_PIPE_TGT_EN
   logic [XLEN-1:0] tag_x;
   if (TAG_W >= XLEN) begin : g_tag_trunc
      assign tag_x = in_tag[XLEN-1:0];
   end else begin : g_tag_zext
      assign tag_x = {{(XLEN-TAG_W){1'b0}}, in_tag};
   end
   assign in_e.tgt = tag_x + in_e.ext;
   assign tgt      = m_q.tgt;
`endif

   // Handshake. in_ready depends only on registered state, so there is no
   // combinational path from out_ready to in_ready.
   assign in_ready  = !s_valid;
   assign in_xfer   = in_valid && in_ready;
   assign out_valid = m_valid;
   assign out_xfer  = m_valid && out_ready;
   assign advance   = !m_valid || out_xfer;
   assign m_load_s  = !flush && advance && s_valid;
   assign m_load_in = !flush && advance && !s_valid && in_xfer;
   assign s_load_in = !flush && in_xfer && (advance ? s_valid : 1'b1);

   assign ext     = m_q.ext;
   assign out_tag = m_q.tag;
   assign op_err  = m_q.err;

   // Occupancy: reset wins over flush, flush wins over any transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         m_valid <= 1'b0;
         s_valid <= 1'b0;
      end else if (flush) begin
         m_valid <= 1'b0;
         s_valid <= 1'b0;
      end else if (advance) begin
         m_valid <= s_valid || in_xfer;
         s_valid <= s_valid && in_xfer;
      end else begin
         s_valid <= s_valid || in_xfer;
      end
   end

   // Main entry payload. Only reset clears it; otherwise it holds while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         m_q <= '0;
      end else if (m_load_s) begin
         m_q <= s_q;
      end else if (m_load_in) begin
         m_q <= in_e;
      end
   end

   // Skid entry payload. It captures the input when the main entry cannot take it.
   always_ff @(posedge clk) begin
      if (rst) begin
         s_q <= '0;
      end else if (s_load_in) begin
         s_q <= in_e;
      end
   end

endmodule

// File: tb/tb_sext_pipe.sv
// tb_sext_pipe: directed tests for sext_pipe with hand-computed expected values.
// A 32-bit instance and a 64-bit instance share the same stimulus.
// Define SEXT_PIPE_TGT_EN to also exercise the tgt output.
module tb_sext_pipe;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic [31:0] inst;
   logic [2:0]  ext_op;
   logic [31:0] in_tag;
   logic        out_ready;

   logic        in_ready,  in_ready64;
   logic        out_valid, out_valid64;
   logic [31:0] ext;
   logic [63:0] ext64;
   logic [31:0] out_tag,   out_tag64;
   logic        op_err,    op_err64;
`ifdef SEXT_PIPE_TGT_EN
   logic [31:0] tgt;
   logic [63:0] tgt64;
`endif

   int errors = 0;
   int checks = 0;

   sext_pipe #(.XLEN(32), .TAG_W(32)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .inst(inst), .ext_op(ext_op), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .ext(ext), .out_tag(out_tag), .op_err(op_err)
`ifdef SEXT_PIPE_TGT_EN
      ,.tgt(tgt)
`endif
   );

   sext_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready64),
      .inst(inst), .ext_op(ext_op), .in_tag(in_tag),
      .out_valid(out_valid64), .out_ready(out_ready),
      .ext(ext64), .out_tag(out_tag64), .op_err(op_err64)
`ifdef SEXT_PIPE_TGT_EN
      ,.tgt(tgt64)
`endif
   );

   // Free-running clock with a 10 ns period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so the bench can never hang
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   localparam logic [31:0] V_INST [0:7] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000EE3, 32'h800000EF,
                                            32'h123452B7, 32'h000FD073, 32'h03F01013, 32'hFFFFFFFF};
   localparam logic [2:0]  V_OP   [0:7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
   localparam logic [31:0] V_EXT  [0:7] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'hFFF00000,
                                            32'h12345000, 32'h0000001F, 32'h0000001F, 32'h00000000};
   localparam logic        V_ERR  [0:7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

   function automatic logic [31:0] immI(input logic [11:0] n);
      return {n, 20'h00013};
   endfunction

   // Offer one instruction for exactly one edge, then check just after that edge
   task automatic applyStimulus(input logic [31:0] i, input logic [2:0] op, input logic [31:0] t);
      @(negedge clk);
      inst = i; ext_op = op; in_tag = t; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (ext !== 32'h0) begin errors++; $display("[TB] FAIL reset_ext: got %h expected 0", ext); end
      checks++; if (op_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_op_err: got %b expected 0", op_err); end
      checks++; if (out_tag !== 32'h0) begin errors++; $display("[TB] FAIL reset_out_tag: got %h expected 0", out_tag); end
   endtask

   task automatic test_formats;
      out_ready = 1'b1;
      for (int v = 0; v < 8; v++) begin
         applyStimulus(V_INST[v], V_OP[v], 32'h100 + 32'(v));
         checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL fmt%0d_valid: got %b expected 1", v, out_valid); end
         checks++; if (ext !== V_EXT[v]) begin errors++; $display("[TB] FAIL fmt%0d_ext: got %h expected %h", v, ext, V_EXT[v]); end
         checks++; if (op_err !== V_ERR[v]) begin errors++; $display("[TB] FAIL fmt%0d_err: got %b expected %b", v, op_err, V_ERR[v]); end
         checks++; if (out_tag !== 32'h100 + 32'(v)) begin errors++; $display("[TB] FAIL fmt%0d_tag: got %h expected %h", v, out_tag, 32'h100 + 32'(v)); end
      end
   endtask

   task automatic test_xlen64;
      out_ready = 1'b1;
      applyStimulus(32'h800002B7, 3'd4, 32'h200);
      checks++; if (ext64 !== 64'hFFFFFFFF80000000) begin errors++; $display("[TB] FAIL x64_u: got %h expected ffffffff80000000", ext64); end
      checks++; if (ext !== 32'h80000000) begin errors++; $display("[TB] FAIL x32_u: got %h expected 80000000", ext); end
      applyStimulus(32'h03F01013, 3'd6, 32'h201);
      checks++; if (ext64 !== 64'h3F) begin errors++; $display("[TB] FAIL x64_sh: got %h expected 3f", ext64); end
      checks++; if (ext !== 32'h1F) begin errors++; $display("[TB] FAIL x32_sh: got %h expected 1f", ext); end
      applyStimulus(32'h800000EF, 3'd3, 32'h202);
      checks++; if (ext64 !== 64'hFFFFFFFFFFF00000) begin errors++; $display("[TB] FAIL x64_j: got %h expected fffffffffff00000", ext64); end
      checks++; if (out_valid64 !== 1'b1 || out_tag64 !== 32'h202) begin errors++; $display("[TB] FAIL x64_tag: got %b/%h expected 1/202", out_valid64, out_tag64); end
   endtask

   task automatic test_back_to_back;
      out_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         inst = immI(12'(k)); ext_op = 3'd0; in_tag = 32'h300 + 32'(k); in_valid = 1'b1;
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b1 || out_tag !== 32'h300 + 32'(k) || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b%0d: got v=%b tag=%h rdy=%b expected v=1 tag=%h rdy=1", k, out_valid, out_tag, in_ready, 32'h300 + 32'(k));
         end
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure;
      int  got;
      logic takeIn;
      got = 0;
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; inst = immI(12'd1); ext_op = 3'd0; in_tag = 32'd1;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || out_tag !== 32'd1 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_first: got v=%b tag=%h rdy=%b expected 1/1/1", out_valid, out_tag, in_ready); end
      @(negedge clk);
      inst = immI(12'd2); in_tag = 32'd2;
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b0 || out_tag !== 32'd1) begin errors++; $display("[TB] FAIL bp_full: got rdy=%b tag=%h expected 0/1", in_ready, out_tag); end
      @(negedge clk);
      inst = immI(12'd3); in_tag = 32'd3;
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b0 || out_tag !== 32'd1 || ext !== 32'd1) begin errors++; $display("[TB] FAIL bp_stall: got rdy=%b tag=%h ext=%h expected 0/1/1", in_ready, out_tag, ext); end
      @(negedge clk);
      out_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         if (out_valid) begin
            checks++;
            if (got >= 3 || out_tag !== 32'(got + 1) || ext !== 32'(got + 1)) begin
               errors++;
               $display("[TB] FAIL bp_order%0d: got tag=%h ext=%h expected %h", got, out_tag, ext, got + 1);
            end
            got++;
         end
         takeIn = in_valid && in_ready;
         @(posedge clk); #1;
         if (takeIn) in_valid = 1'b0;
         @(negedge clk);
      end
      checks++; if (got !== 3) begin errors++; $display("[TB] FAIL bp_count: got %0d expected 3", got); end
      checks++; if (in_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_tag3_accept: got in_valid=%b expected 0", in_valid); end
   endtask

   task automatic test_flush;
      int seen;
      seen = 0;
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; inst = immI(12'h0A1); ext_op = 3'd0; in_tag = 32'hA1;
      @(posedge clk); #1;
      @(negedge clk);
      in_tag = 32'hA2;
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL fl_full: got rdy=%b v=%b expected 0/1", in_ready, out_valid); end
      @(negedge clk);
      in_tag = 32'hA3; flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL fl_clear: got v=%b rdy=%b expected 0/1", out_valid, in_ready); end
      @(negedge clk);
      in_valid = 1'b1; in_tag = 32'hB1; flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL fl_drop_input: got v=%b expected 0", out_valid); end
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL fl_no_output: got %0d entries expected 0", seen); end
   endtask

   task automatic test_reset_midstream;
      int seen;
      seen = 0;
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; inst = 32'h12345678; ext_op = 3'd7; in_tag = 32'hC1;
      @(posedge clk); #1;
      @(negedge clk);
      in_tag = 32'hC2;
      @(posedge clk); #1;
      checks++; if (op_err !== 1'b1 || out_tag !== 32'hC1 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL rs_full: got err=%b tag=%h rdy=%b expected 1/c1/0", op_err, out_tag, in_ready); end
      @(negedge clk);
      in_tag = 32'hC3; rst = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rs_valid: got v=%b rdy=%b expected 0/1", out_valid, in_ready); end
      checks++; if (out_tag !== 32'h0 || op_err !== 1'b0 || ext !== 32'h0) begin errors++; $display("[TB] FAIL rs_data: got tag=%h err=%b ext=%h expected 0/0/0", out_tag, op_err, ext); end
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL rs_no_output: got %0d entries expected 0", seen); end
   endtask

`ifdef SEXT_PIPE_TGT_EN
   task automatic test_tgt;
      out_ready = 1'b1;
      applyStimulus(32'hFE000EE3, 3'd2, 32'h00001000);
      checks++; if (tgt !== 32'h00000FFC) begin errors++; $display("[TB] FAIL tgt_b: got %h expected 00000ffc", tgt); end
      checks++; if (tgt64 !== 64'h0000000000000FFC) begin errors++; $display("[TB] FAIL tgt64_b: got %h expected ffc", tgt64); end
      applyStimulus(32'h0200006F, 3'd3, 32'hFFFFFFF0);
      checks++; if (ext !== 32'h20) begin errors++; $display("[TB] FAIL tgt_j_ext: got %h expected 20", ext); end
      checks++; if (tgt !== 32'h00000010) begin errors++; $display("[TB] FAIL tgt_wrap: got %h expected 00000010", tgt); end
      checks++; if (tgt64 !== 64'h0000000100000010) begin errors++; $display("[TB] FAIL tgt64_j: got %h expected 100000010", tgt64); end
   endtask
`endif

   // Main sequence
   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; inst = '0; ext_op = '0;
      in_tag = '0; out_ready = 1'b0;
      $display("[TB] sext_pipe directed tests starting");
      test_reset();
      test_formats();
      test_xlen64();
      test_back_to_back();
      test_backpressure();
      test_flush();
      test_reset_midstream();
`ifdef SEXT_PIPE_TGT_EN
      test_tgt();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sext_pipe.md
Name: sext_pipe

Overview:
- Parametrised, registered successor to the combinational immediate extender.
- Sits between the fetch/decode boundary and the ID/EX register.
- Accepts an instruction word plus an extension opcode and a sideband tag, and produces the sign- or zero-extended immediate one cycle later behind a valid/ready handshake.
- Includes a 2-entry skid buffer, flush support and XLEN generalisation.

Parameters:
- XLEN, 32, datapath width of `ext`; legal values 32 or 64 only.
- TAG_W, 32, width of the sideband tag carried alongside each instruction (normally the PC).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous pipeline kill; drops all buffered entries.
- in_valid  input  1  upstream has an instruction.
- in_ready  output  1  block can accept this cycle.
- inst  input  32  raw instruction word.
- ext_op  input  3  extension format.
- in_tag  input  TAG_W  sideband tag.
- out_valid  output  1  `ext`/`out_tag` are valid.
- out_ready  input  1  downstream accepts.
- ext  output  XLEN  extended immediate.
- out_tag  output  TAG_W  tag paired with `ext`.
- op_err  output  1  entry at output had an illegal `ext_op`.

Behaviour:
- ext_op encoding (from defines.vh):
  - 0 EXT_I, 1 EXT_S, 2 EXT_B, 3 EXT_J, 4 EXT_U.
  - 5 EXT_Z (CSR zimm).
  - 6 EXT_SH (shift amount).
  - 7 illegal.
- Formats; all sign extension is from inst[31] up to XLEN:
  - I: inst[31:20].
  - S: inst[31:25], inst[11:7].
  - B: inst[31], inst[7], inst[30:25], inst[11:8], 0.
  - J: inst[31], inst[19:12], inst[20], inst[30:21], 0.
  - U: inst[31:12] followed by 12 zero bits, sign-extended above bit 31 when XLEN=64.
  - Z: inst[19:15] zero-extended.
  - SH: inst[24:20] zero-extended for XLEN=32; inst[25:20] zero-extended for XLEN=64.
  - Illegal: ext=0 and op_err=1 for that entry.
- Extension is computed combinationally at the input and captured into the buffer, so each entry stores {ext, tag, err}.
- Storage:
  - Main register M and skid register S, each with its own valid bit.
  - Outputs always drive from M.
- Handshake:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - in_ready = !S.valid, registered-state only; no combinational path from out_ready.
- Latency:
  - 1 cycle from input transfer to out_valid when M is empty or is draining that same cycle.
  - Sustained throughput is 1 per cycle.
- Per-edge update:
  - M empty, or M draining (out transfer): M loads S if S is valid, otherwise M loads the input if there is an input transfer, otherwise M becomes invalid. S loads the input if S was valid and there is an input transfer; otherwise S becomes invalid.
  - M holding (no out transfer) with an input transfer: the input goes to S. This is only possible when S is empty.
- Ordering is strictly FIFO.
- While out_valid && !out_ready, ext, out_tag and op_err are held stable.
- flush:
  - M.valid and S.valid are cleared at the edge.
  - A same-cycle input transfer is discarded.
  - in_ready is 1 the next cycle.
  - flush takes priority over every transfer.
- rst:
  - M.valid=0, S.valid=0, ext=0, out_tag=0, op_err=0, in_ready=1 after the edge.
  - rst takes priority over flush.
  - rst asserted mid-stream discards both entries.
- Data registers are cleared only by rst. flush clears only the valid bits; ext/out_tag may retain stale values while out_valid=0.

Optional Feature:
- Macro SEXT_PIPE_TGT_EN.
- Defined:
  - Adds output `tgt` (XLEN), computed as out_tag + ext mod 2^XLEN. The tag is zero-extended or truncated to XLEN.
  - `tgt` is registered alongside the entry, so it is valid with out_valid and obeys the same stability and reset-to-0 rules.
  - Used for early branch/JAL target calculation.
- Not defined: port `tgt` and its adder are absent; all other behaviour is identical.

Test Plan:
- Reset/idle: rst=1 for 2 cycles, then 0 -> in_ready=1, out_valid=0, ext=0, op_err=0.
- Format sweep, XLEN=32:
  - inst=0xFFF00093, op=I -> ext=0xFFFFFFFF.
  - inst=0xFE000EE3, op=B -> ext=0xFFFFFFFC.
  - inst=0x800000EF, op=J -> ext=0xFFF00000.
  - inst=0x123452B7, op=U -> ext=0x12345000.
  - inst=0x000FD073, op=Z -> ext=0x1F.
  - op=7 -> ext=0, op_err=1.
  - Each result appears 1 cycle after the input transfer.
- XLEN=64:
  - inst=0x800002B7, op=U -> ext=0xFFFFFFFF80000000.
  - inst=0x03F01013, op=SH -> ext=0x3F.
- Backpressure: stream tags 1,2,3 with out_ready=0 -> after 2 accepts in_ready=0, tag 3 stalls, out_tag=1 stable. Raise out_ready -> tags 1,2,3 emerge in order, one per cycle, with no loss or duplication.
- Flush/reset: with both entries full, assert flush together with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the stalled input is never output. Repeat with rst instead -> outputs are 0.
- SEXT_PIPE_TGT_EN defined: tag=0x00001000, inst=0xFE000EE3, op=B -> tgt=0x00000FFC. With tag=0xFFFFFFF0, op=J, ext=0x20 -> tgt=0x00000010, wrapping mod 2^32.
